// File: rtl/nanov_spi_arbiter.sv
// nanov_spi_arbiter
//   Shares one SPI RAM/flash between the nanoV instruction-fetch port (0,
//   read only) and data port (1, read/write). Whole 32-bit word transactions
//   are serialised one bit per clk: command, 24-bit address, optional read
//   turnaround, 32 data bits (byte 0 first, each byte MSB first), one gap.
//
// Parameters
//   READ_DELAY : turnaround cycles between the address and read data (0..7).
// Optional feature
//   SPI_ARB_ROUND_ROBIN_EN : when defined, ties alternate between ports;
//                            otherwise port 1 always wins a tie.
// Ports
//   clk, rst                    : clock, synchronous active-high reset
//   req0_valid/addr/ready       : fetch request handshake
//   rsp0_valid/data             : fetch response strobe and word
//   req1_valid/write/addr/wdata/ready : data request handshake
//   rsp1_valid/data             : data response strobe (0 data on write ack)
//   spi_select                  : chip select, active low
//   spi_clk_enable              : gate enable for the external SPI clock
//   spi_out, spi_data_in        : MOSI, MISO
module nanov_spi_arbiter #(
  parameter int unsigned READ_DELAY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [23:0] req0_addr,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [23:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic        spi_select,
  output logic        spi_clk_enable,
  output logic        spi_out,
  input  logic        spi_data_in
);

  localparam int unsigned CNT_W     = 6;
  localparam int unsigned CMD_BITS  = 8;
  localparam int unsigned ADDR_BITS = 24;
  localparam int unsigned DATA_BITS = 32;
  localparam int unsigned TX_BITS   = CMD_BITS + ADDR_BITS + DATA_BITS;
  localparam logic [7:0]  CMD_READ  = 8'h03;
  localparam logic [7:0]  CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WAIT,
    S_DATA,
    S_GAP
  } state_t;

  // Byte 0 travels first on the wire, so the wire stream is the byte-swapped word.
  function automatic logic [31:0] f_bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 r_rdy0, w_rdy0_nxt;
  logic                 r_rdy1, w_rdy1_nxt;
  logic                 r_port, w_port_nxt;
  logic                 r_write, w_write_nxt;
  logic [TX_BITS-1:0]   r_tx, w_tx_nxt;
  logic [DATA_BITS-1:0] r_rx, w_rx_nxt;
  logic                 r_sel, w_sel_nxt;
  logic                 r_clken, w_clken_nxt;
  logic                 r_rsp0_v, w_rsp0_v_nxt;
  logic                 r_rsp1_v, w_rsp1_v_nxt;
  logic [DATA_BITS-1:0] r_rsp0_d, w_rsp0_d_nxt;
  logic [DATA_BITS-1:0] r_rsp1_d, w_rsp1_d_nxt;
  logic                 w_decide;
  logic                 w_gnt0, w_gnt1;
  logic                 w_acc_write;
  logic [23:0]          w_acc_addr;
  logic [DATA_BITS-1:0] w_rx_last;

  // Grant selection; only consumed on cycles where w_decide is set.
`ifdef SPI_ARB_ROUND_ROBIN_EN
  logic r_last1;

  always_comb begin
    w_gnt1 = req1_valid & (~req0_valid | ~r_last1);
    w_gnt0 = req0_valid & ~w_gnt1;
  end

  // Remembers which port won the most recent grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last1 <= 1'b0;
    end else if (w_decide && (w_gnt0 || w_gnt1)) begin
      r_last1 <= w_gnt1;
    end
  end
`else
  always_comb begin
    w_gnt1 = req1_valid;
    w_gnt0 = req0_valid & ~req1_valid;
  end
`endif

  // Request fields are captured on the edge that ends the ready cycle.
  assign w_acc_write = r_rdy1 & req1_write;
  assign w_acc_addr  = r_rdy1 ? req1_addr : req0_addr;
  assign w_rx_last   = {r_rx[DATA_BITS-2:0], spi_data_in};

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = CNT_W'(r_cnt - CNT_W'(1));
    w_rdy0_nxt   = 1'b0;
    w_rdy1_nxt   = 1'b0;
    w_port_nxt   = r_port;
    w_write_nxt  = r_write;
    w_tx_nxt     = r_tx;
    w_rx_nxt     = r_rx;
    w_sel_nxt    = r_sel;
    w_clken_nxt  = r_clken;
    w_rsp0_v_nxt = 1'b0;
    w_rsp1_v_nxt = 1'b0;
    w_rsp0_d_nxt = r_rsp0_d;
    w_rsp1_d_nxt = r_rsp1_d;
    w_decide     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_rdy0 || r_rdy1) begin
          // Ready cycle: commit the granted request and start the command.
          w_state_nxt = S_CMD;
          w_cnt_nxt   = CNT_W'(CMD_BITS - 1);
          w_port_nxt  = r_rdy1;
          w_write_nxt = w_acc_write;
          w_tx_nxt    = {(w_acc_write ? CMD_WRITE : CMD_READ), w_acc_addr,
                         (w_acc_write ? f_bswap(req1_wdata) : 32'h0)};
          w_sel_nxt   = 1'b0;
          w_clken_nxt = 1'b1;
        end else begin
          w_decide = 1'b1;
        end
      end
      S_CMD: begin
        w_tx_nxt = {r_tx[TX_BITS-2:0], 1'b0};
        if (r_cnt == CNT_W'(0)) begin
          w_state_nxt = S_ADDR;
          w_cnt_nxt   = CNT_W'(ADDR_BITS - 1);
        end
      end
      S_ADDR: begin
        w_tx_nxt = {r_tx[TX_BITS-2:0], 1'b0};
        if (r_cnt == CNT_W'(0)) begin
          if (!r_write && (READ_DELAY != 0)) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_W'(READ_DELAY - 1);
          end else begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = CNT_W'(DATA_BITS - 1);
          end
        end
      end
      S_WAIT: begin
        // The tx register is all zero here, so MOSI idles low.
        if (r_cnt == CNT_W'(0)) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = CNT_W'(DATA_BITS - 1);
        end
      end
      S_DATA: begin
        w_tx_nxt = {r_tx[TX_BITS-2:0], 1'b0};
        if (!r_write) begin
          w_rx_nxt = w_rx_last;
        end
        if (r_cnt == CNT_W'(0)) begin
          w_state_nxt = S_GAP;
          w_sel_nxt   = 1'b1;
          w_clken_nxt = 1'b0;
          if (r_port) begin
            w_rsp1_v_nxt = 1'b1;
            w_rsp1_d_nxt = r_write ? 32'h0 : f_bswap(w_rx_last);
          end else begin
            w_rsp0_v_nxt = 1'b1;
            w_rsp0_d_nxt = f_bswap(w_rx_last);
          end
        end
      end
      S_GAP: begin
        // Arbitrate here so the next ready lands on the first IDLE cycle.
        w_state_nxt = S_IDLE;
        w_decide    = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = 1'b1;
        w_clken_nxt = 1'b0;
      end
    endcase

    if (w_decide) begin
      w_rdy0_nxt = w_gnt0;
      w_rdy1_nxt = w_gnt1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= CNT_W'(0);
      r_rdy0   <= 1'b0;
      r_rdy1   <= 1'b0;
      r_port   <= 1'b0;
      r_write  <= 1'b0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_sel    <= 1'b1;
      r_clken  <= 1'b0;
      r_rsp0_v <= 1'b0;
      r_rsp1_v <= 1'b0;
      r_rsp0_d <= '0;
      r_rsp1_d <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rdy0   <= w_rdy0_nxt;
      r_rdy1   <= w_rdy1_nxt;
      r_port   <= w_port_nxt;
      r_write  <= w_write_nxt;
      r_tx     <= w_tx_nxt;
      r_rx     <= w_rx_nxt;
      r_sel    <= w_sel_nxt;
      r_clken  <= w_clken_nxt;
      r_rsp0_v <= w_rsp0_v_nxt;
      r_rsp1_v <= w_rsp1_v_nxt;
      r_rsp0_d <= w_rsp0_d_nxt;
      r_rsp1_d <= w_rsp1_d_nxt;
    end
  end

  assign req0_ready     = r_rdy0;
  assign req1_ready     = r_rdy1;
  assign rsp0_valid     = r_rsp0_v;
  assign rsp0_data      = r_rsp0_d;
  assign rsp1_valid     = r_rsp1_v;
  assign rsp1_data      = r_rsp1_d;
  assign spi_select     = r_sel;
  assign spi_clk_enable = r_clken;
  assign spi_out        = r_tx[TX_BITS-1];

endmodule

// File: tb/tb_nanov_spi_arbiter.sv
// Bench for nanov_spi_arbiter: two instances (READ_DELAY 0 and 3), each
// attached to a behavioural SPI memory that decodes MOSI and drives MISO.
module tb_nanov_spi_arbiter;

  localparam int RD_U1 = 3;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  logic        req0_valid[2], req0_ready[2], rsp0_valid[2];
  logic        req1_valid[2], req1_write[2], req1_ready[2], rsp1_valid[2];
  logic        spi_select[2], spi_clk_enable[2], spi_out[2], spi_data_in[2];
  logic [23:0] req0_addr[2], req1_addr[2];
  logic [31:0] req1_wdata[2], rsp0_data[2], rsp1_data[2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nanov_spi_arbiter #(.READ_DELAY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid[0]), .req0_addr(req0_addr[0]), .req0_ready(req0_ready[0]),
    .rsp0_valid(rsp0_valid[0]), .rsp0_data(rsp0_data[0]),
    .req1_valid(req1_valid[0]), .req1_write(req1_write[0]), .req1_addr(req1_addr[0]),
    .req1_wdata(req1_wdata[0]), .req1_ready(req1_ready[0]),
    .rsp1_valid(rsp1_valid[0]), .rsp1_data(rsp1_data[0]),
    .spi_select(spi_select[0]), .spi_clk_enable(spi_clk_enable[0]),
    .spi_out(spi_out[0]), .spi_data_in(spi_data_in[0]));

  nanov_spi_arbiter #(.READ_DELAY(RD_U1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid[1]), .req0_addr(req0_addr[1]), .req0_ready(req0_ready[1]),
    .rsp0_valid(rsp0_valid[1]), .rsp0_data(rsp0_data[1]),
    .req1_valid(req1_valid[1]), .req1_write(req1_write[1]), .req1_addr(req1_addr[1]),
    .req1_wdata(req1_wdata[1]), .req1_ready(req1_ready[1]),
    .rsp1_valid(rsp1_valid[1]), .rsp1_data(rsp1_data[1]),
    .spi_select(spi_select[1]), .spi_clk_enable(spi_clk_enable[1]),
    .spi_out(spi_out[1]), .spi_data_in(spi_data_in[1]));

  // Device memory (written from MOSI) and reference memory (written from requests).
  logic [7:0] dev_mem [int];
  logic [7:0] ref_mem [int];

  function automatic int key(input int u, input int a);
    return u * 32'h0100_0000 + a;
  endfunction

  function automatic logic [7:0] def_byte(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_byte(input bit dev, input int u, input int a);
    if (dev) return dev_mem.exists(key(u, a)) ? dev_mem[key(u, a)] : def_byte(a);
    return ref_mem.exists(key(u, a)) ? ref_mem[key(u, a)] : def_byte(a);
  endfunction

  function automatic logic [31:0] mem_word(input bit dev, input int u, input int a);
    return {mem_byte(dev, u, a + 3), mem_byte(dev, u, a + 2),
            mem_byte(dev, u, a + 1), mem_byte(dev, u, a)};
  endfunction

  task automatic preload(input int u, input int a, input logic [7:0] b);
    dev_mem[key(u, a)] = b;
    ref_mem[key(u, a)] = b;
  endtask

  // SPI memory model: bit k counts clocked select-low cycles from 0.
  int          m_k[2]   = '{0, 0};
  int          m_err[2] = '{0, 0};
  logic [31:0] m_hdr[2];
  logic [7:0]  m_cmd[2];
  logic [23:0] m_addr[2];
  logic [7:0]  m_wb[2];

  always @(negedge clk) begin
    int k, j, rd;
    logic [7:0] b;
    for (int u = 0; u < 2; u++) begin
      rd = (u == 1) ? RD_U1 : 0;
      spi_data_in[u] = 1'($urandom);
      if (!spi_select[u] && spi_clk_enable[u]) begin
        k = m_k[u];
        if (k < 32) begin
          m_hdr[u] = {m_hdr[u][30:0], spi_out[u]};
          if (k == 31) begin
            m_cmd[u]  = m_hdr[u][31:24];
            m_addr[u] = m_hdr[u][23:0];
          end
        end else if (m_cmd[u] == 8'h03) begin
          if (spi_out[u] !== 1'b0) m_err[u]++;
          if (k >= 32 + rd && k < 64 + rd) begin
            j = k - 32 - rd;
            b = mem_byte(1'b1, u, int'(m_addr[u]) + j / 8);
            spi_data_in[u] = b[7 - (j % 8)];
          end
        end else if (m_cmd[u] == 8'h02 && k < 64) begin
          j = k - 32;
          m_wb[u] = {m_wb[u][6:0], spi_out[u]};
          if (j % 8 == 7) dev_mem[key(u, int'(m_addr[u]) + j / 8)] = m_wb[u];
        end
        m_k[u] = k + 1;
      end else begin
        m_k[u] = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One complete transaction on instance u, port p; returns at the cycle after the response.
  task automatic run_txn(input int u, input int p, input bit wr, input logic [23:0] addr,
                         input logic [31:0] wdata, input int lat, input logic [31:0] rdata,
                         input int max_wait);
    int a_cyc, got_lat, errs0;
    bit got, stray;
    errs0 = m_err[u];
    if (p == 0) begin
      req0_valid[u] = 1'b1; req0_addr[u] = addr;
    end else begin
      req1_valid[u] = 1'b1; req1_write[u] = wr; req1_addr[u] = addr; req1_wdata[u] = wdata;
    end
    got = 1'b0;
    a_cyc = 0;
    for (int i = 0; i < max_wait && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? req0_ready[u] : req1_ready[u]) begin
        got = 1'b1;
        a_cyc = cyc;
        chk("other ready low", 32'((p == 0) ? req1_ready[u] : req0_ready[u]), 32'd0);
      end
    end
    chk("accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    req0_valid[u] = 1'b0; req1_valid[u] = 1'b0;
    req0_addr[u] = 24'($urandom); req1_addr[u] = 24'($urandom);
    req1_wdata[u] = $urandom; req1_write[u] = 1'($urandom);
    if (!got) return;
    if (wr) for (int b = 0; b < 4; b++) ref_mem[key(u, int'(addr) + b)] = wdata[8*b +: 8];
    got = 1'b0; stray = 1'b0; got_lat = -1;
    for (int i = 0; i < 120 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? rsp1_valid[u] : rsp0_valid[u]) stray = 1'b1;
      if ((p == 0) ? rsp0_valid[u] : rsp1_valid[u]) begin
        got = 1'b1;
        got_lat = cyc - a_cyc;
      end
    end
    chk("rsp latency", 32'(got_lat), 32'(lat));
    chk("no stray rsp", 32'(stray), 32'd0);
    chk("rsp data", (p == 0) ? rsp0_data[u] : rsp1_data[u], rdata);
    chk("gap select", 32'(spi_select[u]), 32'd1);
    chk("gap clk_en", 32'(spi_clk_enable[u]), 32'd0);
    chk("spi cmd", 32'(m_cmd[u]), wr ? 32'h02 : 32'h03);
    chk("spi addr", 32'(m_addr[u]), 32'(addr));
    chk("mosi idle low", 32'(m_err[u] - errs0), 32'd0);
    if (wr) chk("written word", mem_word(1'b1, u, int'(addr)), mem_word(1'b0, u, int'(addr)));
    @(negedge clk);
    chk("rsp one pulse", 32'((p == 0) ? rsp0_valid[u] : rsp1_valid[u]), 32'd0);
  endtask

  typedef struct {
    int          u;
    int          port;
    bit          wr;
    logic [23:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int a, lat0, lat1, first0, u, p;
    bit wr, got;
    logic [23:0] ad;
    logic [31:0] wd;

    tbl[0] = '{0, 0, 1'b0, 24'h000104, 32'h0,         65,         32'h00000013};
    tbl[1] = '{0, 1, 1'b1, 24'h000200, 32'hDEADBEEF,  65,         32'h0};
    tbl[2] = '{0, 1, 1'b0, 24'h000200, 32'h0,         65,         32'hDEADBEEF};
    tbl[3] = '{0, 0, 1'b0, 24'h000200, 32'h0,         65,         32'hDEADBEEF};
    tbl[4] = '{1, 1, 1'b0, 24'h000104, 32'h0,         65 + RD_U1, 32'h00000013};
    tbl[5] = '{1, 0, 1'b0, 24'h000300, 32'h0,         65 + RD_U1, 32'h44332211};
    tbl[6] = '{1, 1, 1'b1, 24'h000300, 32'hCAFEF00D,  65,         32'h0};
    tbl[7] = '{1, 1, 1'b0, 24'h000300, 32'h0,         65 + RD_U1, 32'hCAFEF00D};

    for (int i = 0; i < 2; i++) begin
      preload(i, 32'h104, 8'h13); preload(i, 32'h105, 8'h00);
      preload(i, 32'h106, 8'h00); preload(i, 32'h107, 8'h00);
      req0_valid[i] = 1'b0; req0_addr[i] = '0;
      req1_valid[i] = 1'b0; req1_write[i] = 1'b0; req1_addr[i] = '0; req1_wdata[i] = '0;
    end
    preload(1, 32'h300, 8'h11); preload(1, 32'h301, 8'h22);
    preload(1, 32'h302, 8'h33); preload(1, 32'h303, 8'h44);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset select", 32'(spi_select[0]), 32'd1);
    chk("reset clk_en", 32'(spi_clk_enable[0]), 32'd0);
    chk("reset mosi", 32'(spi_out[0]), 32'd0);
    chk("reset readys", 32'({req0_ready[0], req1_ready[0]}), 32'd0);
    chk("reset rsp valids", 32'({rsp0_valid[0], rsp1_valid[0]}), 32'd0);
    chk("reset rsp0 data", rsp0_data[0], 32'd0);
    chk("reset rsp1 data", rsp1_data[1], 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_txn(tbl[i].u, tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
              tbl[i].lat, tbl[i].rdata, 4);

`ifndef SPI_ARB_ROUND_ROBIN_EN
    // Simultaneous requests: port 1 first, port 0 on the first IDLE cycle after it.
    req0_valid[0] = 1'b1; req0_addr[0] = 24'h000104;
    req1_valid[0] = 1'b1; req1_write[0] = 1'b1; req1_addr[0] = 24'h000208;
    req1_wdata[0] = 32'h01020304;
    got = 1'b0; a = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (req0_ready[0] || req1_ready[0]) begin got = 1'b1; a = cyc; end
    end
    chk("tie ready1", 32'(req1_ready[0]), 32'd1);
    chk("tie ready0", 32'(req0_ready[0]), 32'd0);
    @(posedge clk); #1 req1_valid[0] = 1'b0;
    for (int b = 0; b < 4; b++) ref_mem[key(0, 32'h208 + b)] = 8'(32'h01020304 >> (8 * b));
    first0 = -1; lat1 = -1;
    for (int i = 0; i < 80 && first0 < 0; i++) begin
      @(negedge clk);
      if (rsp1_valid[0]) lat1 = cyc - a;
      if (req0_ready[0]) first0 = cyc - a;
    end
    chk("tie rsp1 latency", 32'(lat1), 32'd65);
    chk("tie rsp1 data", rsp1_data[0], 32'd0);
    chk("tie port0 accept", 32'(first0), 32'd66);
    @(posedge clk); #1 req0_valid[0] = 1'b0;
    lat0 = -1;
    for (int i = 0; i < 80 && lat0 < 0; i++) begin
      @(negedge clk);
      if (rsp0_valid[0]) lat0 = cyc - (a + 66);
    end
    chk("tie rsp0 latency", 32'(lat0), 32'd65);
    chk("tie rsp0 data", rsp0_data[0], mem_word(1'b0, 0, 32'h104));
    chk("tie written word", mem_word(1'b1, 0, 32'h208), mem_word(1'b0, 0, 32'h208));
    @(negedge clk);
`endif

    // Reset in the middle of the address phase drops the transaction.
    req0_valid[0] = 1'b1; req0_addr[0] = 24'h000104;
    got = 1'b0; a = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (req0_ready[0]) begin got = 1'b1; a = cyc; end
    end
    chk("pre-reset accept", 32'(got), 32'd1);
    @(posedge clk); #1 req0_valid[0] = 1'b0;
    for (int i = 0; i < 40 && cyc < a + 20; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    req0_valid[0] = 1'b1; req0_addr[0] = 24'h000200;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid reset select", 32'(spi_select[0]), 32'd1);
    chk("mid reset clk_en", 32'(spi_clk_enable[0]), 32'd0);
    chk("mid reset rsp0", 32'(rsp0_valid[0]), 32'd0);
    run_txn(0, 0, 1'b0, 24'h000200, 32'h0, 65, mem_word(1'b0, 0, 32'h200), 2);

`ifdef SPI_ARB_ROUND_ROBIN_EN
    // Round robin after reset: continuous ties alternate starting with port 1.
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    req0_valid[0] = 1'b1; req0_addr[0] = 24'h000104;
    req1_valid[0] = 1'b1; req1_write[0] = 1'b0; req1_addr[0] = 24'h000200;
    for (int t = 0; t < 4; t++) begin
      got = 1'b0;
      for (int i = 0; i < 80 && !got; i++) begin
        @(negedge clk);
        if (req0_ready[0] || req1_ready[0]) begin
          got = 1'b1;
          chk("rr grant", 32'(req1_ready[0]), (t % 2 == 0) ? 32'd1 : 32'd0);
        end
      end
      chk("rr accept", 32'(got), 32'd1);
    end
    @(posedge clk); #1 req0_valid[0] = 1'b0; req1_valid[0] = 1'b0;
    repeat (70) @(negedge clk);
`endif

    // Randomised traffic against the reference memory.
    for (int i = 0; i < 24; i++) begin
      u  = int'($urandom_range(0, 1));
      p  = int'($urandom_range(0, 1));
      wr = (p == 1) && ($urandom_range(0, 1) == 1);
      ad = 24'(32'h400 + $urandom_range(0, 60));
      wd = $urandom;
      run_txn(u, p, wr, ad, wd, wr ? 65 : 65 + ((u == 1) ? RD_U1 : 0),
              wr ? 32'h0 : mem_word(1'b0, u, int'(ad)), 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/nanov_spi_arbiter.md
# nanov_spi_arbiter

Bit-serial SPI memory controller that shares one external SPI RAM/flash between two requesters: port 0 is the CPU instruction fetch (read only), port 1 is CPU data load/store (read/write). It sits between the nanoV CPU and the SPI pins. It arbitrates whole 32-bit word transactions, serialises command, address and data one bit per `clk`, and returns read words on a per-port response strobe.

## Interface
Parameters:
- `READ_DELAY`, default 0: extra turnaround cycles between the last address bit and the first sampled read bit; range 0–7.

Ports:
- `clk` in 1: single clock; the SPI clock is `clk` gated externally by `spi_clk_enable`.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: fetch request; held high until accepted.
- `req0_addr` in 24: fetch byte address.
- `req0_ready` out 1: one-cycle accept pulse for port 0.
- `rsp0_valid` out 1: one-cycle pulse; `rsp0_data` valid.
- `rsp0_data` out 32: fetched word, little-endian.
- `req1_valid` in 1: data request; held high until accepted.
- `req1_write` in 1: 1 = write, 0 = read.
- `req1_addr` in 24: data byte address.
- `req1_wdata` in 32: write word.
- `req1_ready` out 1: one-cycle accept pulse for port 1.
- `rsp1_valid` out 1: one-cycle pulse; read data, or write-done acknowledge.
- `rsp1_data` out 32: read word; 0 on write acknowledge.
- `spi_select` out 1: chip select, active low.
- `spi_clk_enable` out 1: gate enable for the SPI clock.
- `spi_out` out 1: MOSI.
- `spi_data_in` in 1: MISO.

## Operation
- States:
  - IDLE: accept a request.
  - CMD: 8 cycles.
  - ADDR: 24 cycles.
  - WAIT: `READ_DELAY` cycles; reads only; skipped when 0.
  - DATA: 32 cycles.
  - GAP: 1 cycle.
- Transitions: IDLE → CMD on accept → ADDR → (WAIT) → DATA → GAP → IDLE.
- A 6-bit bit counter reloads at each state entry.
- Commands are 0x03 (read) and 0x02 (write), sent MSB first.
- The 24-bit address is sent MSB first.
- Data is byte 0 (`[7:0]`) first, each byte MSB first. Read bits assemble in the same order.
- Arbitration happens in IDLE only, and only on `reqN_valid`. With both valid, port 1 wins. Port 0 is always a read.
- The accepted address, write flag and write data are latched at accept. Inputs are don't-care afterwards.
- Only one transaction is in flight. Both readys are 0 outside IDLE.
- Reset values: `spi_select`=1; `rsp0_data` and `rsp1_data` = 0; all other outputs = 0. The state machine resets to IDLE.
- Reset mid-transaction:
  - Next edge: `spi_select`=1, `spi_clk_enable`=0.
  - The in-flight request is dropped with no response.
  - Requesters must re-issue.
- `rspN_data` holds its value until the next response on that port.

## Timing
Cycle A is the IDLE cycle with `reqN_ready`=1; R = `READ_DELAY` for reads, 0 for writes.
- A+1 … A+8: `spi_select`=0, `spi_clk_enable`=1; `spi_out` carries command bits 7…0.
- A+9 … A+32: address bits 23…0.
- A+33 … A+32+R: WAIT; `spi_out`=0, clock running.
- A+33+R … A+64+R: data phase.
  - Writes drive `spi_out`.
  - Reads sample `spi_data_in` at the rising edge ending each cycle; `spi_out`=0.
- A+65+R: GAP.
  - `spi_select`=1, `spi_clk_enable`=0.
  - `rspN_valid`=1 with final data.
- A+66+R: IDLE; the earliest next accept.
- All outputs are registered.
- Accept-to-response latency: 65 cycles (write); 65+`READ_DELAY` (read).

## Configuration
- `SPI_ARB_ROUND_ROBIN_EN` undefined: fixed priority, port 1 over port 0.
- `SPI_ARB_ROUND_ROBIN_EN` defined:
  - With both valid, grant the port not granted last.
  - The last-grant flop resets to port 0, so the first tie goes to port 1.
  - A single valid requester is always granted immediately.

## Test plan
- Reset, then port 0 read addr 0x000104 with `READ_DELAY`=0 and model returning bytes 0x13,0x00,0x00,0x00:
  - `req0_ready` at A.
  - MOSI carries 0x03 then 0x000104.
  - `rsp0_valid` at A+65, `rsp0_data`=0x00000013.
- Port 1 write 0xDEADBEEF to 0x000200:
  - MOSI carries 0x02, 0x000200, then 0xEF,0xBE,0xAD,0xDE.
  - `rsp1_valid` at A+65, `rsp1_data`=0.
  - `spi_select` high at A+65.
- Both valid in the same cycle, fixed priority:
  - Port 1 is granted first.
  - Port 0 is accepted at A+66.
  - `req0_ready` stays low until then.
- Round-robin build, both requesters continuously valid for 4 transactions: grants are 1,0,1,0.
- `rst` asserted at A+20:
  - Next cycle `spi_select`=1, `spi_clk_enable`=0.
  - No `rsp0_valid`/`rsp1_valid` follows.
  - A new request is accepted in the first cycle after `rst` deasserts.
- `READ_DELAY`=3, port 1 read: `rsp1_valid` at A+68, and the sample window is shifted by 3.
